// File: rtl/keccak_pkg.sv
// keccak_pkg: sponge geometry helpers, domain-separation bytes and padder FSM states.
package keccak_pkg;
  localparam logic [7:0] DS_SHA3  = 8'h06;
  localparam logic [7:0] DS_SHAKE = 8'h1F;
  typedef enum logic [1:0] {ABSORB, PAD, EMIT, EXTRA} state_t;
  function automatic int f_w(input int l);
    return 1 << l;
  endfunction
  function automatic int f_b(input int l);
    return 25 * f_w(l);
  endfunction
  function automatic int f_c(input int d);
    return 2 * d;
  endfunction
  function automatic int f_r(input int d, input int l);
    return f_b(l) - f_c(d);
  endfunction
  function automatic int f_rbytes(input int d, input int l);
    return f_r(d, l) / 8;
  endfunction
endpackage

// File: rtl/keccak_pad.sv
// keccak_pad: packs a byte stream into rate-sized blocks and applies pad10*1 with a domain byte.
module keccak_pad
  import keccak_pkg::*;
#(
  parameter int          d  = 112,
  parameter int          l  = 6,
  parameter logic [7:0]  DS = 8'h06
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [f_r(d, l)-1:0]    blk_data,
  output logic                    blk_valid,
  output logic                    blk_last,
  input  logic                    blk_ready
);
  localparam int RW = f_r(d, l);
  localparam int R  = f_rbytes(d, l);
  localparam int IW = $clog2(R);
  localparam logic [IW-1:0] IDX_END = IW'(R - 1);
  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_idx, r_p;
  logic            r_pend, r_last, r_run;
  logic [RW-1:0]   r_buf, w_pad;
  logic            w_in_fire, w_blk_fire, w_idx_end;
  assign in_ready   = r_run && r_state == ABSORB;
  assign blk_valid  = r_state == EMIT;
  assign blk_last   = r_last;
  assign blk_data   = r_buf;
  assign w_in_fire  = in_valid && in_ready;
  assign w_blk_fire = blk_valid && blk_ready;
  assign w_idx_end  = r_idx == IDX_END;
  // Domain byte at p, zeros after it, then the closing 1 bit in the top byte.
  always_comb begin
    w_pad = r_buf;
    for (int j = 0; j < R; j++) begin
      if (j == int'(r_p)) w_pad[j*8 +: 8] = DS;
      else if (j > int'(r_p)) w_pad[j*8 +: 8] = 8'h00;
    end
    w_pad[RW-1 -: 8] = w_pad[RW-1 -: 8] | 8'h80;
  end
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ABSORB:  w_state_nxt = !w_in_fire ? ABSORB : w_idx_end ? EMIT : in_last ? PAD : ABSORB;
      PAD:     w_state_nxt = EMIT;
      EMIT:    w_state_nxt = !w_blk_fire ? EMIT : r_pend ? PAD : ABSORB;
      default: w_state_nxt = ABSORB;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= ABSORB;
    else r_state <= w_state_nxt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_idx  <= '0;
      r_p    <= '0;
      r_pend <= 1'b0;
      r_last <= 1'b0;
      r_run  <= 1'b0;
      r_buf  <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_in_fire) begin
        r_buf[{r_idx, 3'b000} +: 8] <= in_data;
        if (w_idx_end) r_pend <= in_last;
        else if (in_last) r_p <= r_idx + IW'(1);
        else r_idx <= r_idx + IW'(1);
      end
      if (r_state == PAD) begin
        r_buf  <= w_pad;
        r_last <= 1'b1;
      end
      if (w_blk_fire) begin
        r_buf  <= '0;
        r_last <= 1'b0;
        r_idx  <= '0;
        r_p    <= '0;
        r_pend <= 1'b0;
      end
    end
endmodule

// File: tb/tb_keccak_pad.sv
// tb_keccak_pad: table-driven and randomized checks of the padder against a block-splitting model.
module tb_keccak_pad;
  localparam int R  = 172;
  localparam int RW = R * 8;
  localparam logic [7:0] DS = 8'h06;
  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [RW-1:0] data;
    logic          last;
  } blk_t;
  typedef struct {
    int         len;
    logic [7:0] base;
    bit         incr;
    bit         gaps;
    bit         rnd;
    bit         drain;
    int         nblk;
  } vec_t;
  logic clk = 0, reset = 0;
  logic [7:0] in_data = 0;
  logic in_valid = 0, in_last = 0, blk_ready = 0;
  logic in_ready, blk_valid, blk_last;
  logic [RW-1:0] blk_data;
  int n_chk = 0, n_err = 0, n_pop = 0;
  bit rnd_ready = 0;
  blk_t exp_q[$];

  keccak_pad dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .blk_data(blk_data), .blk_valid(blk_valid), .blk_last(blk_last),
    .blk_ready(blk_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rnd_ready) blk_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic abort(input string name);
    n_err++;
    $display("FAIL %s timeout", name);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  endtask

  task automatic cmp_block(input blk_t e);
    int bad = -1;
    for (int i = 0; i < R; i++)
      if (bad < 0 && blk_data[i*8 +: 8] !== e.data[i*8 +: 8]) bad = i;
    n_chk++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL blk_data byte %0d got %h exp %h", bad, blk_data[bad*8 +: 8], e.data[bad*8 +: 8]);
    end
    check("blk_last", 64'(blk_last), 64'(e.last));
  endtask

  always @(negedge clk)
    if (reset && blk_valid && blk_ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_block got last=%0b exp none", blk_last);
      end else cmp_block(exp_q.pop_front());
    end

  // Model: full rate blocks carry data only; the tail (possibly empty) gets DS then the final 0x80.
  task automatic push_msg(input byte_q_t msg);
    int n = msg.size();
    int nf = n / R;
    int rem = n % R;
    blk_t b;
    for (int k = 0; k < nf; k++) begin
      b.data = '0;
      for (int i = 0; i < R; i++) b.data[i*8 +: 8] = msg[k*R + i];
      b.last = 1'b0;
      exp_q.push_back(b);
    end
    b.data = '0;
    for (int i = 0; i < rem; i++) b.data[i*8 +: 8] = msg[nf*R + i];
    b.data[rem*8 +: 8] = DS;
    b.data[RW-1] = 1'b1;
    b.last = 1'b1;
    exp_q.push_back(b);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input bit gaps);
    int t = 0;
    bit fire = 0;
    if (gaps)
      while ($urandom_range(0, 3) == 0) begin
        in_valid = 0;
        @(posedge clk); #1;
      end
    in_valid = 1;
    in_data = d;
    in_last = last;
    while (!fire && t < 3000) begin
      @(negedge clk);
      fire = in_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!fire) abort("in_handshake");
  endtask

  task automatic send_msg(input byte_q_t msg, input bit gaps);
    push_msg(msg);
    for (int i = 0; i < msg.size(); i++) send_byte(msg[i], i == msg.size() - 1, gaps);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_left", 64'(exp_q.size()), 0);
  endtask

  task automatic wait_valid(input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!blk_valid && t < 1000);
    if (!blk_valid) abort(name);
  endtask

  initial begin
    vec_t vecs[8];
    byte_q_t m;
    logic [RW-1:0] cd;
    logic cl;
    int p0;
    vecs[0] = '{1,   8'hAB, 1, 0, 0, 1, 1};
    vecs[1] = '{171, 8'h01, 1, 0, 0, 1, 1};
    vecs[2] = '{172, 8'h01, 1, 0, 0, 1, 2};
    vecs[3] = '{200, 8'h00, 0, 0, 0, 0, 0};
    vecs[4] = '{3,   8'h00, 0, 0, 0, 1, 3};
    vecs[5] = '{344, 8'h00, 0, 1, 1, 1, 3};
    vecs[6] = '{343, 8'h00, 0, 1, 1, 1, 2};
    vecs[7] = '{170, 8'h10, 1, 1, 1, 1, 1};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 0);
    check("rst_blk_valid", 64'(blk_valid), 0);
    check("rst_blk_last", 64'(blk_last), 0);
    reset = 1;
    @(posedge clk); #1;
    check("in_ready_after_rst", 64'(in_ready), 1);
    blk_ready = 1;
    p0 = n_pop;
    foreach (vecs[v]) begin
      rnd_ready = vecs[v].rnd;
      if (!vecs[v].rnd) blk_ready = 1;
      m = {};
      for (int i = 0; i < vecs[v].len; i++)
        m.push_back(vecs[v].incr ? 8'(vecs[v].base + 8'(i)) : 8'($urandom));
      send_msg(m, vecs[v].gaps);
      if (vecs[v].drain) begin
        in_valid = 0;
        wait_drain();
        check("nblk", 64'(n_pop - p0), 64'(vecs[v].nblk));
        p0 = n_pop;
      end
    end
    rnd_ready = 0;
    blk_ready = 1;
    in_valid = 0;
    m = {8'h3C};
    push_msg(m);
    send_byte(8'h3C, 1, 0);
    in_valid = 0;
    @(negedge clk);
    check("lat_pad_valid", 64'(blk_valid), 0);
    @(negedge clk);
    check("lat_last_valid", 64'(blk_valid), 1);
    wait_drain();
    m = {};
    for (int i = 0; i < R + 1; i++) m.push_back(8'($urandom));
    push_msg(m);
    for (int i = 0; i < R; i++) send_byte(m[i], 0, 0);
    in_valid = 0;
    @(negedge clk);
    check("lat_fill_valid", 64'(blk_valid), 1);
    send_byte(m[R], 1, 0);
    in_valid = 0;
    wait_drain();
    blk_ready = 0;
    m = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    push_msg(m);
    for (int i = 0; i < 5; i++) send_byte(m[i], i == 4, 0);
    in_valid = 1;
    in_data = 8'h77;
    in_last = 1;
    wait_valid("stall_valid");
    cd = blk_data;
    cl = blk_last;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_chk++;
      if (blk_data !== cd) begin
        n_err++;
        $display("FAIL stall_data got %h exp %h", blk_data[63:0], cd[63:0]);
      end
      check("stall_last", 64'(blk_last), 64'(cl));
      check("stall_in_ready", 64'(in_ready), 0);
    end
    blk_ready = 1;
    m = {8'h77};
    send_msg(m, 0);
    in_valid = 0;
    wait_drain();
    for (int i = 0; i < 50; i++) send_byte(8'($urandom_range(1, 255)), 0, 0);
    in_valid = 0;
    reset = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_rst_in_ready", 64'(in_ready), 0);
    check("mid_rst_blk_valid", 64'(blk_valid), 0);
    reset = 1;
    m = {8'h55};
    send_msg(m, 0);
    in_valid = 0;
    wait_drain();
    blk_ready = 0;
    for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i), i == 2, 0);
    in_valid = 0;
    wait_valid("emit_before_rst");
    #2 reset = 0;
    #1 check("async_rst_valid", 64'(blk_valid), 0);
    @(negedge clk);
    reset = 1;
    blk_ready = 1;
    m = {8'h9D, 8'h9E};
    send_msg(m, 0);
    in_valid = 0;
    wait_drain();
    rnd_ready = 1;
    for (int k = 0; k < 6; k++) begin
      m = {};
      repeat ($urandom_range(1, 400)) m.push_back(8'($urandom));
      send_msg(m, 1);
    end
    in_valid = 0;
    wait_drain();
    rnd_ready = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
